// File: rtl/cache_arb_pkg.sv
// Purpose : shared types for the I/D-cache to physical-memory arbiter.
// Latency : n/a (types, constants and a pure helper function only).
// Backpr. : n/a.
//
// Contents: arbiter state encoding, requester identity, default bus widths
// and the round-robin pick used when the arbiter is idle.
package cache_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ICACHE = 2'd1,
        ARB_DCACHE = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_ICACHE = 1'b0,
        REQ_DCACHE = 1'b1
    } requester_t;

    // Round-robin choice between the two requesters. Only meaningful when at
    // least one of them is requesting; with a single requester it wins
    // outright, with both the one that did not win last time is chosen.
    function automatic requester_t rr_pick(
        input logic       i_req,
        input logic       d_req,
        input requester_t last
    );
        if (i_req && d_req) begin
            return (last == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
        end else if (i_req) begin
            return REQ_ICACHE;
        end else begin
            return REQ_DCACHE;
        end
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Purpose : shares the single line-wide memory port between icache and dcache.
// Latency : request seen in IDLE at cycle N -> memory request from cycle N+1;
//           one IDLE cycle after every memory response.
// Backpr. : requesters hold a level request until their own resp pulse; the
//           loser simply waits, nothing is queued inside the arbiter.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   i_pmem_read/address           icache line-read request (level)
//   i_pmem_rdata/resp             line data and completion pulse to icache
//   d_pmem_read/write/address/wdata  dcache line read / writeback request
//   d_pmem_rdata/resp             line data and completion pulse to dcache
//   pmem_read/write/address/wdata request to memory for the granted side
//   pmem_rdata/resp               line data and completion from memory
module cache_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t state;
    requester_t last_grant;

    logic       i_req;
    logic       d_req;
    requester_t pick;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;
    assign pick  = rr_pick(i_req, d_req, last_grant);

    // Grant FSM. Requests are only looked at in IDLE; once granted the
    // arbiter is locked to that side until memory signals completion, even
    // if the requester misbehaves and drops its request early. last_grant
    // resets to the dcache so the first contended grant goes to the icache.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            last_grant <= REQ_DCACHE;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (i_req || d_req) begin
                        state      <= (pick == REQ_ICACHE) ? ARB_ICACHE : ARB_DCACHE;
                        last_grant <= pick;
                    end
                end
                ARB_ICACHE, ARB_DCACHE: begin
                    if (pmem_resp) begin
                        state <= ARB_IDLE;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Output steering depends only on the registered state, so there is no
    // combinational path from a request through the arbitration decision to
    // the memory strobes. In IDLE everything is quiet, which also keeps a
    // stray pmem_resp from being forwarded to either cache.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        case (state)
            ARB_ICACHE: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_rdata = pmem_rdata;
                i_pmem_resp  = pmem_resp;
            end
            ARB_DCACHE: begin
                // Read and write are passed through as driven; an illegal
                // read+write from the dcache reaches memory unchanged.
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_rdata = pmem_rdata;
                d_pmem_resp  = pmem_resp;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    // Memory side is driven either by the directed code (a_*) or by the
    // memory model (m_*), selected by mon_en.
    logic          mon_en;
    logic          a_resp, m_resp;
    logic [LW-1:0] a_rdata, m_rdata;
    assign pmem_resp  = mon_en ? m_resp  : a_resp;
    assign pmem_rdata = mon_en ? m_rdata : a_rdata;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic wr; logic [AW-1:0] addr; logic [LW-1:0] wdata; } mem_txn_t;
    typedef struct { logic who; logic [LW-1:0] data; } resp_t;

    mem_txn_t exp_i[$];
    mem_txn_t exp_d[$];
    resp_t    exp_resp[$];
    bit       grant_log[$];   // 0 = icache, 1 = dcache, in grant order

    int            checks = 0;
    int            fails  = 0;
    int unsigned   fix_lat = 0;
    bit            fix_rd_en = 0;
    logic [LW-1:0] fix_rd = '0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_zero(input string tag);
        chk_b({tag, ".pmem_read"}, pmem_read, 1'b0);
        chk_b({tag, ".pmem_write"}, pmem_write, 1'b0);
        chk_w({tag, ".pmem_address"}, LW'(pmem_address), '0);
        chk_w({tag, ".pmem_wdata"}, pmem_wdata, '0);
        chk_b({tag, ".i_resp"}, i_pmem_resp, 1'b0);
        chk_b({tag, ".d_resp"}, d_pmem_resp, 1'b0);
        chk_w({tag, ".i_rdata"}, i_pmem_rdata, '0);
        chk_w({tag, ".d_rdata"}, d_pmem_rdata, '0);
    endtask

    // While a side owns memory its request must appear on the memory port
    // unchanged and the other side must see nothing.
    task automatic busy_checks(input bit owner, input mem_txn_t e);
        chk_b("busy.pmem_read", pmem_read, !e.wr);
        chk_b("busy.pmem_write", pmem_write, e.wr);
        chk_w("busy.pmem_address", LW'(pmem_address), LW'(e.addr));
        chk_w("busy.pmem_wdata", pmem_wdata, owner ? e.wdata : '0);
        if (owner) begin
            chk_b("busy.i_resp_quiet", i_pmem_resp, 1'b0);
            chk_w("busy.i_rdata_quiet", i_pmem_rdata, '0);
        end else begin
            chk_b("busy.d_resp_quiet", d_pmem_resp, 1'b0);
            chk_w("busy.d_rdata_quiet", d_pmem_rdata, '0);
        end
    endtask

    task automatic chk_log(input string name, input int n, input logic [7:0] pat);
        logic [LW-1:0] act;
        act = '0;
        act[15:8] = 8'(grant_log.size());
        for (int i = 0; i < grant_log.size() && i < 8; i++) act[i] = grant_log[i];
        chk_w(name, act, {240'd0, 8'(n), pat});
        grant_log.delete();
    endtask

    // ---------------- requester agents ----------------
    task automatic i_txn(input logic [AW-1:0] addr, output logic [LW-1:0] rdat);
        bit got;
        @(posedge clk); #1;
        i_pmem_read    = 1'b1;
        i_pmem_address = addr;
        exp_i.push_back('{wr: 1'b0, addr: addr, wdata: '0});
        got  = 0;
        rdat = '0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (i_pmem_resp) begin
                got  = 1;
                rdat = i_pmem_rdata;
            end
        end
        chk_b("i_resp_arrives", got, 1'b1);
    endtask

    task automatic i_release(input int gap);
        @(posedge clk); #1;
        i_pmem_read = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic d_txn(input logic wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wdata, output logic [LW-1:0] rdat);
        bit got;
        @(posedge clk); #1;
        d_pmem_read    = !wr;
        d_pmem_write   = wr;
        d_pmem_address = addr;
        d_pmem_wdata   = wdata;
        exp_d.push_back('{wr: wr, addr: addr, wdata: wdata});
        got  = 0;
        rdat = '0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (d_pmem_resp) begin
                got  = 1;
                rdat = d_pmem_rdata;
            end
        end
        chk_b("d_resp_arrives", got, 1'b1);
    endtask

    task automatic d_release(input int gap);
        @(posedge clk); #1;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    // ---------------- memory model + grant reference ----------------
    // Reference rule: a request present during an idle cycle is granted on
    // the next cycle; with both present the side not granted last time wins.
    // Memory holds each transaction for a random number of cycles.
    initial begin : mem_model
        bit            owner, m_last, busy, idle_prev, sched, drop, gnt, exp_g;
        bit            prev_i, prev_d;
        mem_txn_t      cur;
        logic [LW-1:0] rd;
        int unsigned   cnt;
        busy = 0; idle_prev = 1; m_last = 1; owner = 0;
        prev_i = 0; prev_d = 0; cnt = 0; rd = '0;
        cur = '{wr: 1'b0, addr: '0, wdata: '0};
        m_resp  = 1'b0;
        m_rdata = rand_line();
        forever begin
            @(negedge clk);
            sched = 0;
            drop  = 0;
            if (mon_en) begin
                if (!busy) begin
                    gnt   = pmem_read | pmem_write;
                    exp_g = idle_prev && (prev_i || prev_d);
                    chk_b("grant_decision", gnt, exp_g);
                    if (gnt && exp_g) begin
                        owner  = (prev_i && prev_d) ? ~m_last : prev_d;
                        m_last = owner;
                        grant_log.push_back(owner);
                        if (owner) begin
                            chk_b("grant_has_d_request", exp_d.size() != 0, 1'b1);
                            if (exp_d.size() != 0) cur = exp_d.pop_front();
                        end else begin
                            chk_b("grant_has_i_request", exp_i.size() != 0, 1'b1);
                            if (exp_i.size() != 0) cur = exp_i.pop_front();
                        end
                        cnt  = (fix_lat != 0) ? fix_lat : $urandom_range(6, 2);
                        rd   = fix_rd_en ? fix_rd : rand_line();
                        busy = 1;
                    end else if (!gnt) begin
                        chk_zero("idle");
                    end
                end
                if (busy) begin
                    busy_checks(owner, cur);
                    if (m_resp) begin
                        busy = 0;
                        drop = 1;
                    end else begin
                        cnt--;
                        if (cnt <= 1) begin
                            sched = 1;
                            exp_resp.push_back('{who: owner, data: rd});
                        end
                    end
                end
                idle_prev = !busy && !drop;
            end
            prev_i = i_pmem_read;
            prev_d = d_pmem_read | d_pmem_write;
            @(posedge clk); #1;
            if (sched) begin
                m_resp  = 1'b1;
                m_rdata = rd;
            end else if (drop) begin
                m_resp  = 1'b0;
                m_rdata = rand_line();
            end
        end
    end

    // ---------------- response monitor ----------------
    initial begin : resp_mon
        resp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && (i_pmem_resp || d_pmem_resp)) begin
                chk_b("single_resp", i_pmem_resp & d_pmem_resp, 1'b0);
                chk_b("resp_expected", exp_resp.size() != 0, 1'b1);
                if (exp_resp.size() != 0) begin
                    e = exp_resp.pop_front();
                    chk_b("resp_owner", d_pmem_resp, e.who);
                    chk_w("resp_rdata", d_pmem_resp ? d_pmem_rdata : i_pmem_rdata, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        logic [LW-1:0] l0, r, w;
        logic [AW-1:0] a;
        logic          wr;
        int            g;

        rst = 1'b0; mon_en = 1'b0;
        a_resp = 1'b0; a_rdata = rand_line();
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_2000;
        d_pmem_read = 1'b1; d_pmem_write = 1'b0;
        d_pmem_address = 32'h0000_3000; d_pmem_wdata = rand_line();

        // Reset held with both requests up: everything quiet.
        repeat (2) begin
            @(negedge clk);
            chk_zero("rst_hold");
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_release");
        @(negedge clk);
        chk_b("post_rst_read", pmem_read, 1'b1);
        chk_b("post_rst_write", pmem_write, 1'b0);
        chk_w("post_rst_addr", LW'(pmem_address), LW'(32'h0000_2000));

        l0 = rand_line();
        @(posedge clk); #1 a_resp = 1'b1; a_rdata = l0;
        @(negedge clk);
        chk_b("first_i_resp", i_pmem_resp, 1'b1);
        chk_w("first_i_rdata", i_pmem_rdata, l0);
        chk_b("first_d_quiet", d_pmem_resp, 1'b0);
        @(posedge clk); #1 a_resp = 1'b0; i_pmem_read = 1'b0;
        @(negedge clk);
        chk_zero("idle_after_i");
        @(negedge clk);
        chk_b("d_grant_read", pmem_read, 1'b1);
        chk_w("d_grant_addr", LW'(pmem_address), LW'(32'h0000_3000));

        // Dcache flips its request mid-transaction: forwarded as driven.
        @(posedge clk); #1 d_pmem_read = 1'b0; d_pmem_write = 1'b1;
        @(negedge clk);
        chk_b("d_flip_write", pmem_write, 1'b1);
        chk_b("d_flip_read", pmem_read, 1'b0);
        chk_w("d_flip_wdata", pmem_wdata, d_pmem_wdata);

        // Reset in the middle of the dcache transaction.
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_zero("mid_txn_reset");

        // Stray memory response while idle is ignored.
        @(posedge clk); #1 rst = 1'b1; d_pmem_write = 1'b0; a_resp = 1'b1; a_rdata = rand_line();
        repeat (3) begin
            @(negedge clk);
            chk_zero("spurious_resp");
        end
        @(posedge clk); #1 a_resp = 1'b0; mon_en = 1'b1;

        // Single icache read, 5-cycle memory, 0xA5 line.
        fix_lat = 5; fix_rd_en = 1; fix_rd = {32{8'hA5}};
        i_txn(32'h0000_1040, r);
        chk_w("single_i_rdata", r, {32{8'hA5}});
        i_release(0);
        fix_rd_en = 0;
        chk_log("order_single_i", 1, 8'b0);

        // Writeback followed by allocate.
        w = {8{32'h1234_5678}};
        d_txn(1'b1, 32'h8000_0020, w, r);
        d_txn(1'b0, 32'h8000_0040, rand_line(), r);
        d_release(1);
        chk_log("order_wb_alloc", 2, 8'b11);

        // Both requesters held for two transactions each: I, D, I, D.
        fix_lat = 0;
        fork
            begin
                i_txn(32'h0000_4000, r);
                i_txn(32'h0000_4020, r);
                i_release(0);
            end
            begin
                d_txn(1'b0, 32'h9000_0000, rand_line(), w);
                d_txn(1'b1, 32'h9000_0020, rand_line(), w);
                d_release(0);
            end
        join
        repeat (2) @(posedge clk);
        chk_log("order_alternate", 4, 8'b1010);

        // Icache arrives during a writeback: served before the allocate.
        fix_lat = 5;
        fork
            begin
                d_txn(1'b1, 32'hA000_0000, rand_line(), w);
                d_txn(1'b0, 32'hA000_0040, rand_line(), w);
                d_release(0);
            end
            begin
                repeat (2) @(posedge clk);
                i_txn(32'h0000_5000, r);
                i_release(0);
            end
        join
        repeat (2) @(posedge clk);
        chk_log("order_wb_contention", 3, 8'b101);

        // Randomised traffic from both sides.
        fix_lat = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    g = int'($urandom_range(3, 0));
                    if (g != 0) i_release(g - 1);
                    a = $urandom; a[4:0] = 5'd0;
                    i_txn(a, r);
                end
                i_release(0);
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    g = int'($urandom_range(3, 0));
                    if (g != 0) d_release(g - 1);
                    a = $urandom; a[4:0] = 5'd0;
                    wr = 1'($urandom_range(1, 0));
                    d_txn(wr, a, rand_line(), w);
                end
                d_release(0);
            end
        join
        repeat (4) @(posedge clk);
        chk_w("left_exp_resp", LW'(exp_resp.size()), '0);
        chk_w("left_exp_i", LW'(exp_i.size()), '0);
        chk_w("left_exp_d", LW'(exp_d.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port (cacheline adaptor side) between the instruction-cache and data-cache controllers of the pipelined CPU.
- Each cache controller issues whole-line read/write requests and holds them until it sees its own response.
- The arbiter grants one requester at a time with round-robin tie-breaking, muxes its request onto memory, and routes the response back.

Parameters:
ADDR_WIDTH, 32, byte address width of line requests (line-aligned by requesters).
LINE_WIDTH, 256, cacheline width in bits.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset (reset applied when rst = 0 at a rising edge)
i_pmem_read  input  1  icache line-read request, level, held until i_pmem_resp
i_pmem_address  input  ADDR_WIDTH  icache line address
i_pmem_rdata  output  LINE_WIDTH  line data to icache
i_pmem_resp  output  1  icache transaction complete, one-cycle pulse
d_pmem_read  input  1  dcache line-read request, level
d_pmem_write  input  1  dcache line-write (writeback) request, level
d_pmem_address  input  ADDR_WIDTH  dcache line address
d_pmem_wdata  input  LINE_WIDTH  dcache writeback line
d_pmem_rdata  output  LINE_WIDTH  line data to dcache
d_pmem_resp  output  1  dcache transaction complete, one-cycle pulse
pmem_read  output  1  line read to memory
pmem_write  output  1  line write to memory
pmem_address  output  ADDR_WIDTH  granted requester's address
pmem_wdata  output  LINE_WIDTH  dcache wdata (0 when not granted to dcache)
pmem_rdata  input  LINE_WIDTH  line from memory
pmem_resp  input  1  memory transaction complete

Behaviour:
- State register, reset to ARB_IDLE. States: ARB_IDLE, ARB_ICACHE, ARB_DCACHE.
- last_grant register (1 bit), reset to DCACHE, so the first contended grant goes to icache.
- Request terms: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
- ARB_IDLE transitions:
  - only i_req -> ARB_ICACHE.
  - only d_req -> ARB_DCACHE.
  - both -> grant the requester not equal to last_grant.
  - neither -> stay.
  - last_grant updates on the granting edge.
- ARB_ICACHE / ARB_DCACHE: hold until pmem_resp = 1, then -> ARB_IDLE on that edge. Requests are not re-evaluated mid-transaction.
- Arbitration latency: request first visible in IDLE at cycle N; pmem_read/pmem_write asserted from cycle N+1. Outputs are combinational from the registered state, so no combinational path from i_/d_ requests to pmem_read/pmem_write through the grant decision.
- Outputs in ARB_IDLE: pmem_read = pmem_write = 0, pmem_address = 0, pmem_wdata = 0, both resp = 0, both rdata = 0.
- Outputs in ARB_ICACHE:
  - pmem_read = i_pmem_read, pmem_write = 0, pmem_address = i_pmem_address.
  - i_pmem_rdata = pmem_rdata, i_pmem_resp = pmem_resp.
  - d_pmem_resp = 0, d_pmem_rdata = 0.
- Outputs in ARB_DCACHE: mirror of ARB_ICACHE using d_ signals; pmem_write = d_pmem_write, pmem_wdata = d_pmem_wdata.
- Reset values of all outputs: 0, i.e. the ARB_IDLE values.
- Cycle after a resp: the arbiter is in IDLE and re-arbitrates. A requester still asserting (new miss phase, e.g. writeback followed by allocate) competes normally.
  - Writeback then allocate with icache waiting: icache is served between the two dcache transactions (round-robin).
- pmem_resp while in ARB_IDLE: ignored, no resp forwarded, no state change.
- Requester deasserting before its resp (protocol violation): the arbiter stays in its grant state until pmem_resp; the request is forwarded as currently driven.
- d_pmem_read and d_pmem_write both asserted: illegal input; both are forwarded as driven; not checked.
- Reset mid-transaction: state -> ARB_IDLE and last_grant -> DCACHE next edge; outputs drop to 0; the in-flight memory transaction is abandoned (memory model is also reset).
- No starvation: with both requesters continuously asserting, grants alternate I, D, I, D.

Decomposition:
- Package cache_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_ICACHE, ARB_DCACHE}.
  - requester_t enum {REQ_ICACHE, REQ_DCACHE}.
  - default ADDR_WIDTH/LINE_WIDTH localparams.
- No sub-module. One state FSM plus a last_grant flop plus an output mux, all in one file.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with both requests asserted -> all outputs 0, state ARB_IDLE; rst = 1 -> pmem_read = 1 with pmem_address = icache address 2 cycles later.
- Single icache read: i_pmem_read = 1, addr 0x0000_1040; memory responds after 5 cycles with line 0xA5...A5 -> pmem_read high 5 cycles; i_pmem_resp pulse with i_pmem_rdata = 0xA5...A5; d_pmem_resp stays 0.
- Dcache writeback then allocate: d_pmem_write addr 0x8000_0020, wdata 0x1234...; after resp, d_pmem_read addr 0x8000_0040 -> pmem_write with matching wdata, one IDLE cycle, then pmem_read with the new address; two d_pmem_resp pulses.
- Simultaneous requests, both held: from reset, grant order I, D, I, D over 4 transactions; i_/d_pmem_resp never both high in the same cycle.
- Contention during writeback: icache requests mid dcache writeback -> icache granted after writeback resp, before the dcache allocate.
- Spurious pmem_resp = 1 in IDLE, plus reset asserted mid dcache transaction -> no resp forwarded; after reset, pmem_write = 0 and state ARB_IDLE.
